key_scanner: RTL and testbench
==============================

KEY_SCANNER -- requirements
Module: key_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000: Clk cycles each column is driven (dwell); the sample point is the last cycle of each dwell; legal range is at least 2.
REQ-002 Parameter DEBOUNCE, default 4: number of consecutive matching samples needed to accept a press or a release; legal range is at least 1.
REQ-003 Parameter REPEAT_SCANS, default 200: number of samples between auto-repeat pulses.
REQ-004 Port Clk, input, 1 bit: the single clock; all logic is on its posedge.
REQ-005 Port Rst, input, 1 bit: asynchronous reset, active-high.
REQ-006 Port EN, input, 1 bit: scan enable, active-high.
REQ-007 Port ROWS, input, 4 bits: matrix row lines, active-low, externally pulled up, asynchronous to Clk.
REQ-008 Port COLS, output, 4 bits: column strobes, active-low, one-cold while scanning.
REQ-009 Port KEY, output, 4 bits: last accepted key code, {col[1:0], row[1:0]}.
REQ-010 Port KEY_VALID, output, 1 bit: one-cycle pulse when KEY updates or repeats.
REQ-011 Port PRESSED, output, 1 bit: high while an accepted key is held.

Function
REQ-012 ROWS passes through a 2-flop synchronizer before any use, giving 2 cycles of input latency.
REQ-013 The column index col cycles 0->1->2->3->0; COLS = ~(4'b0001 << col); col advances on the dwell counter's wrap (SCAN_DIV-1) only in state SCAN.
REQ-014 States are SCAN, DEBOUNCE, HELD and RELEASE, all transitioning at sample points only.
REQ-015 In SCAN, any synchronized row low at a sample captures cand = {col, lowest-indexed low row}, holds col, clears match_cnt, and moves to DEBOUNCE.
REQ-016 In DEBOUNCE, a sample with the captured row low increments match_cnt; when match_cnt reaches DEBOUNCE, the block updates KEY to cand, pulses KEY_VALID and enters HELD; a sample with the captured row high returns to SCAN and col advances.
REQ-017 In HELD, PRESSED is 1; a sample with the captured row high enters RELEASE with a count of 1; other rows are ignored.
REQ-018 In RELEASE, a captured-row-high sample increments the count; at DEBOUNCE the block goes to SCAN, PRESSED drops to 0 and col advances; a captured-row-low sample returns to HELD with no new pulse.
REQ-019 Simultaneous keys in one column resolve to the lowest row index; keys in other columns are not seen until release.
REQ-020 EN low, sampled synchronously: COLS=4'hF, state goes to SCAN, col and all counters clear, KEY_VALID=0, PRESSED=0, KEY holds its value; scanning resumes at col 0 on the first edge with EN high.
REQ-021 Counters saturate and never wrap; the dwell counter is ceil(log2(SCAN_DIV)) bits wide.

Reset
REQ-022 While Rst is high: COLS=4'hF, KEY=4'h0, KEY_VALID=0, PRESSED=0, state=SCAN, col=0, all counters and the synchronizer at 0/idle (synchronizer flops at 1).
REQ-023 Rst asserted mid-debounce or mid-hold discards the press without producing a pulse; after deassertion the first dwell drives COLS=4'hE.

Configuration
REQ-024 Macro KEY_SCANNER_REPEAT_EN defined: in HELD, after REPEAT_SCANS consecutive held samples KEY_VALID pulses again with KEY unchanged, and this repeats every REPEAT_SCANS samples; the repeat count clears on entering HELD, including re-entry from RELEASE.
REQ-025 Macro KEY_SCANNER_REPEAT_EN undefined: exactly one KEY_VALID pulse per accepted press; REPEAT_SCANS is ignored and no repeat counter is synthesized.

Structure
REQ-026 Package key_scanner_pkg holds the state enum, KEY_W=4, COLS_OFF=4'hF, and the ROWS/COLS width constant 4.
REQ-027 Sub-module key_sync is the 2-flop, width-parameterized synchronizer, reset to all ones; everything else resides in key_scanner.

Verification (bench uses SCAN_DIV=4, DEBOUNCE=2, REPEAT_SCANS=3)
REQ-028 Reset, then idle with ROWS=4'hF: COLS steps E->D->B->7->E every 4 cycles; KEY_VALID never asserts.
REQ-029 Key at col 2, row 1 held steady: exactly one KEY_VALID pulse with KEY=4'h9, PRESSED=1 and COLS frozen at 4'hB; after release plus 2 samples, PRESSED=0 and COLS=4'h7.
REQ-030 Bounce with row 1 low for 1 sample, then high, in col 2: no pulse, and the block returns to scanning.
REQ-031 Rows 3 and 0 low together in col 1: KEY=4'h4.
REQ-032 With KEY_SCANNER_REPEAT_EN defined and a held key: pulses at acceptance, then every 3 samples; with the macro undefined, exactly one pulse.
REQ-033 EN dropped during HELD, or Rst pulsed during DEBOUNCE: COLS=4'hF, no pulse, KEY keeps its prior value (EN case) or becomes 4'h0 (Rst case).

Source files
------------

// File: rtl/key_scanner_pkg.sv
// key_scanner_pkg -- shared types and constants for the 4x4 key matrix scanner.
//   state_e         : scanner FSM states
//   KEY_W / MAT_W   : key code width and matrix row/column width
//   COLS_OFF        : column strobe value with no column driven
//   lowest_low_row  : index of the lowest-numbered active-low row
//   col_strobe      : one-cold column strobe for a column index
package key_scanner_pkg;

  localparam int KEY_W = 4;
  localparam int MAT_W = 4;
  localparam logic [MAT_W-1:0] COLS_OFF = 4'hF;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  // Walking from the top row down leaves the lowest low row as the winner.
  function automatic logic [1:0] lowest_low_row(input logic [MAT_W-1:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = MAT_W - 1; i >= 0; i--) begin
      if (!rows[i]) begin
        idx = 2'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [MAT_W-1:0] col_strobe(input logic [1:0] col);
    return ~(4'b0001 << col);
  endfunction

endpackage

// File: rtl/key_sync.sv
// key_sync -- two-flop synchronizer for asynchronous active-low lines.
//   clk_i : sampling clock
//   rst_i : asynchronous reset, active-high; both stages reset to all ones (idle)
//   d_i   : asynchronous input
//   q_o   : synchronized output, two cycles of latency
module key_sync #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two-stage capture; resetting to ones keeps released keys idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= {W{1'b1}};
      sync_q <= {W{1'b1}};
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_scanner.sv
// key_scanner -- 4x4 key matrix scanner with debounce.
//   Clk       : clock, all logic on posedge
//   Rst       : asynchronous reset, active-high
//   EN        : synchronous scan enable
//   ROWS      : active-low row lines (asynchronous, pulled up)
//   COLS      : active-low, one-cold column strobes (4'hF when idle)
//   KEY       : last accepted key {col[1:0], row[1:0]}
//   KEY_VALID : one-cycle pulse on acceptance (and on auto-repeat)
//   PRESSED   : high while an accepted key is held
// Optional feature: define KEY_SCANNER_REPEAT_EN to get auto-repeat pulses
// every REPEAT_SCANS samples while a key is held.
module key_scanner
  import key_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_SCANS = 200
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             EN,
  input  logic [MAT_W-1:0] ROWS,
  output logic [MAT_W-1:0] COLS,
  output logic [KEY_W-1:0] KEY,
  output logic             KEY_VALID,
  output logic             PRESSED
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [MAT_W-1:0] rows_sync_s;
  logic             sample_s;
  logic             any_low_s;
  logic             cand_low_s;
  logic [1:0]       low_row_s;
  logic [1:0]       col_next_s;

  state_e           state_q;
  logic             run_q;
  logic [DW-1:0]    dwell_q;
  logic [1:0]       col_q;
  logic [CW-1:0]    cnt_q;
  logic [KEY_W-1:0] cand_q;
  logic [MAT_W-1:0] cols_q;
  logic [KEY_W-1:0] key_q;
  logic             kv_q;
  logic             pressed_q;

`ifdef KEY_SCANNER_REPEAT_EN
  localparam int REP_EFF = (REPEAT_SCANS < 1) ? 1 : REPEAT_SCANS;
  localparam int RW = $clog2(REP_EFF + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REP_EFF - 1);
  localparam logic [RW-1:0] REP_MAX = {RW{1'b1}};
  logic [RW-1:0] rep_q;
`endif

  key_sync #(.W(MAT_W)) u_sync (
    .clk_i (Clk),
    .rst_i (Rst),
    .d_i   (ROWS),
    .q_o   (rows_sync_s)
  );

  // run_q gates sampling so the first dwell after reset/enable is full length.
  assign sample_s   = run_q && (dwell_q == DIV_LAST);
  assign any_low_s  = (rows_sync_s != COLS_OFF);
  assign low_row_s  = lowest_low_row(rows_sync_s);
  assign cand_low_s = ~rows_sync_s[cand_q[1:0]];
  assign col_next_s = col_q + 2'd1;

  // Scanner FSM: dwell timing, column walk, debounce, hold/release and outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= ST_SCAN;
      run_q     <= 1'b0;
      dwell_q   <= {DW{1'b0}};
      col_q     <= 2'd0;
      cnt_q     <= {CW{1'b0}};
      cand_q    <= {KEY_W{1'b0}};
      cols_q    <= COLS_OFF;
      key_q     <= {KEY_W{1'b0}};
      kv_q      <= 1'b0;
      pressed_q <= 1'b0;
`ifdef KEY_SCANNER_REPEAT_EN
      rep_q     <= {RW{1'b0}};
`endif
    end else if (!EN) begin
      // KEY deliberately keeps its value while disabled.
      state_q   <= ST_SCAN;
      run_q     <= 1'b0;
      dwell_q   <= {DW{1'b0}};
      col_q     <= 2'd0;
      cnt_q     <= {CW{1'b0}};
      cols_q    <= COLS_OFF;
      kv_q      <= 1'b0;
      pressed_q <= 1'b0;
`ifdef KEY_SCANNER_REPEAT_EN
      rep_q     <= {RW{1'b0}};
`endif
    end else begin
      kv_q <= 1'b0;
      if (!run_q) begin
        run_q  <= 1'b1;
        cols_q <= col_strobe(col_q);
      end else if (!sample_s) begin
        dwell_q <= dwell_q + DW'(1);
      end else begin
        dwell_q <= {DW{1'b0}};
        case (state_q)
          ST_SCAN: begin
            if (any_low_s) begin
              cand_q  <= {col_q, low_row_s};
              cnt_q   <= {CW{1'b0}};
              state_q <= ST_DEBOUNCE;
            end else begin
              col_q  <= col_next_s;
              cols_q <= col_strobe(col_next_s);
            end
          end
          ST_DEBOUNCE: begin
            if (cand_low_s) begin
              // cnt_q holds matches so far; this sample is one more.
              if (cnt_q >= DEB_LAST) begin
                key_q     <= cand_q;
                kv_q      <= 1'b1;
                pressed_q <= 1'b1;
                cnt_q     <= {CW{1'b0}};
                state_q   <= ST_HELD;
`ifdef KEY_SCANNER_REPEAT_EN
                rep_q     <= {RW{1'b0}};
`endif
              end else begin
                cnt_q <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
              end
            end else begin
              state_q <= ST_SCAN;
              col_q   <= col_next_s;
              cols_q  <= col_strobe(col_next_s);
            end
          end
          ST_HELD: begin
            if (!cand_low_s) begin
              // The first high sample already counts toward release.
              if (DEB_LAST == {CW{1'b0}}) begin
                state_q   <= ST_SCAN;
                pressed_q <= 1'b0;
                col_q     <= col_next_s;
                cols_q    <= col_strobe(col_next_s);
              end else begin
                state_q <= ST_RELEASE;
                cnt_q   <= CW'(1);
              end
            end else begin
`ifdef KEY_SCANNER_REPEAT_EN
              if (rep_q >= REP_LAST) begin
                kv_q  <= 1'b1;
                rep_q <= {RW{1'b0}};
              end else begin
                rep_q <= (rep_q == REP_MAX) ? rep_q : rep_q + RW'(1);
              end
`else
              state_q <= ST_HELD;
`endif
            end
          end
          ST_RELEASE: begin
            if (!cand_low_s) begin
              if (cnt_q >= DEB_LAST) begin
                state_q   <= ST_SCAN;
                pressed_q <= 1'b0;
                cnt_q     <= {CW{1'b0}};
                col_q     <= col_next_s;
                cols_q    <= col_strobe(col_next_s);
              end else begin
                cnt_q <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
              end
            end else begin
              state_q <= ST_HELD;
              cnt_q   <= {CW{1'b0}};
`ifdef KEY_SCANNER_REPEAT_EN
              rep_q   <= {RW{1'b0}};
`endif
            end
          end
          default: begin
            state_q <= ST_SCAN;
          end
        endcase
      end
    end
  end

  assign COLS      = cols_q;
  assign KEY       = key_q;
  assign KEY_VALID = kv_q;
  assign PRESSED   = pressed_q;

endmodule

// File: tb/tb_key_scanner.sv
module tb_key_scanner;

  logic       Clk;
  logic       Rst;
  logic       EN;
  logic [3:0] ROWS;
  logic [3:0] COLS;
  logic [3:0] KEY;
  logic       KEY_VALID;
  logic       PRESSED;

  logic [3:0] key_mat [4];
  int         vecs;
  int         errs;
  int         kv_total;
  int         base;
  int         n;
  logic [3:0] idle_seq [4];

`ifdef KEY_SCANNER_REPEAT_EN
  localparam int EXP_PULSES = 3;
`else
  localparam int EXP_PULSES = 1;
`endif

  key_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE     (2),
    .REPEAT_SCANS (3)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .EN        (EN),
    .ROWS      (ROWS),
    .COLS      (COLS),
    .KEY       (KEY),
    .KEY_VALID (KEY_VALID),
    .PRESSED   (PRESSED)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Matrix model: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    ROWS = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (COLS[c] == 1'b0) ROWS = ROWS & ~key_mat[c];
    end
  end

  always @(posedge Clk) begin
    if (KEY_VALID === 1'b1) kv_total <= kv_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_kv(input int limit, output int cnt);
    bit seen;
    seen = 1'b0;
    cnt  = 0;
    while (!seen && cnt < limit) begin
      @(negedge Clk);
      cnt++;
      if (KEY_VALID === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_released(input int limit, output int cnt);
    bit seen;
    seen = 1'b0;
    cnt  = 0;
    while (!seen && cnt < limit) begin
      @(negedge Clk);
      cnt++;
      if (PRESSED === 1'b0) seen = 1'b1;
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    kv_total = 0;
    idle_seq[0] = 4'hD;
    idle_seq[1] = 4'hB;
    idle_seq[2] = 4'h7;
    idle_seq[3] = 4'hE;
    for (int c = 0; c < 4; c++) key_mat[c] = 4'h0;
    Rst = 1'b1;
    EN  = 1'b1;

    // Reset state
    repeat (3) @(negedge Clk);
    check("rst_cols", COLS, 4'hF);
    check("rst_key", KEY, 4'h0);
    check("rst_kv", KEY_VALID, 1'b0);
    check("rst_pressed", PRESSED, 1'b0);

    // Idle scan: E, D, B, 7, E with 4-cycle dwell
    Rst = 1'b0;
    base = kv_total;
    @(negedge Clk);
    check("idle_first_col", COLS, 4'hE);
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge Clk);
      check("idle_col_step", COLS, idle_seq[i]);
    end
    check("idle_no_kv", kv_total - base, 0);

    // Clean press at col 2 row 1
    base = kv_total;
    key_mat[2] = 4'b0010;
    wait_kv(100, n);
    check("press_kv", KEY_VALID, 1'b1);
    check("press_key", KEY, 4'h9);
    check("press_pressed", PRESSED, 1'b1);
    check("press_cols_frozen", COLS, 4'hB);
`ifdef KEY_SCANNER_REPEAT_EN
    for (int r = 0; r < 2; r++) begin
      wait_kv(40, n);
      check("repeat_interval", n, 12);
      check("repeat_key", KEY, 4'h9);
    end
`else
    repeat (24) @(negedge Clk);
    check("single_pulse", kv_total - base, 1);
    check("held_cols", COLS, 4'hB);
`endif
    key_mat[2] = 4'b0000;
    wait_released(40, n);
    check("release_latency", n, 8);
    check("release_pressed", PRESSED, 1'b0);
    check("release_cols", COLS, 4'h7);
    check("release_key", KEY, 4'h9);
    check("press_pulse_total", kv_total - base, EXP_PULSES);

    // Bounce: row 1 low for one sample in col 2
    base = kv_total;
    key_mat[2] = 4'b0010;
    repeat (16) @(negedge Clk);
    check("bounce_captured", COLS, 4'hB);
    key_mat[2] = 4'b0000;
    repeat (4) @(negedge Clk);
    check("bounce_resume", COLS, 4'h7);
    check("bounce_pressed", PRESSED, 1'b0);
    check("bounce_no_kv", kv_total - base, 0);

    // Rows 3 and 0 together in col 1 resolve to row 0
    key_mat[1] = 4'b1001;
    wait_kv(100, n);
    check("multi_kv", KEY_VALID, 1'b1);
    check("multi_key", KEY, 4'h4);
    check("multi_cols", COLS, 4'hD);

    // EN dropped while held
    EN = 1'b0;
    @(negedge Clk);
    base = kv_total;
    check("en_cols", COLS, 4'hF);
    check("en_pressed", PRESSED, 1'b0);
    check("en_kv", KEY_VALID, 1'b0);
    check("en_key_kept", KEY, 4'h4);
    repeat (8) @(negedge Clk);
    check("en_no_kv", kv_total - base, 0);
    key_mat[1] = 4'b0000;
    EN = 1'b1;
    @(negedge Clk);
    check("en_resume_col0", COLS, 4'hE);

    // Rst during debounce at col 0 row 2
    key_mat[0] = 4'b0100;
    repeat (4) @(negedge Clk);
    check("deb_captured", COLS, 4'hE);
    Rst = 1'b1;
    base = kv_total;
    repeat (2) @(negedge Clk);
    check("rstdeb_cols", COLS, 4'hF);
    check("rstdeb_key", KEY, 4'h0);
    check("rstdeb_pressed", PRESSED, 1'b0);
    check("rstdeb_kv", KEY_VALID, 1'b0);
    key_mat[0] = 4'b0000;
    Rst = 1'b0;
    @(negedge Clk);
    check("rstdeb_first_dwell", COLS, 4'hE);
    repeat (16) @(negedge Clk);
    check("rstdeb_no_kv", kv_total - base, 0);
    check("rstdeb_key_after", KEY, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
